delay_line_prog: RTL
====================

DELAY_LINE_PROG -- requirements
Module: delay_line_prog

Interface
REQ-001 Parameter DATA_W, default 16: sample width in bits.
REQ-002 Parameter MAX_DEPTH, default 64: maximum delay in samples; power of two, >= 2.
REQ-003 Parameter LEN_W, default 7: width of DELAY_LEN; covers 0..MAX_DEPTH.
REQ-004 Parameter DELAY_INIT, default 1: active delay after reset.
REQ-005 CLK  input  1  single clock; all state updates on its rising edge.
REQ-006 RST_N  input  1  reset; synchronous, active-low.
REQ-007 EN  input  1  sample strobe; Xin is accepted in a cycle where EN=1.
REQ-008 Xin  input  DATA_W  input sample.
REQ-009 DELAY_LEN  input  LEN_W  requested delay in samples; sampled only when LOAD=1.
REQ-010 LOAD  input  1  one-cycle request to latch DELAY_LEN as the active delay.
REQ-011 Xin_DELAY  output  DATA_W  registered delayed sample.
REQ-012 DOUT_VALID  output  1  one-cycle pulse: Xin_DELAY updated with a valid delayed sample.
REQ-013 BUSY  output  1  high while the line is priming after reset or LOAD.

Function
REQ-014 Delay is counted in accepted samples (EN cycles), not clock cycles; cycles with EN=0 change no state except LOAD handling.
REQ-015 Storage: circular buffer of MAX_DEPTH words of DATA_W; write pointer wraps modulo MAX_DEPTH; read address = (wr_ptr - active_delay) mod MAX_DEPTH.
REQ-016 Read-before-write: with active_delay = MAX_DEPTH, the word read is the old content at wr_ptr, overwritten by Xin in that same cycle.
REQ-017 On EN=1 with active_delay = D >= 1 and line primed: the Xin accepted D EN-strobes earlier appears on Xin_DELAY the cycle after, with DOUT_VALID=1 that cycle.
REQ-018 active_delay = 0: Xin_DELAY <= Xin one cycle after EN, DOUT_VALID pulses every EN; BUSY=0.
REQ-019 Fill counter counts accepted samples since reset/LOAD, saturating at MAX_DEPTH; line primed when fill >= active_delay (count before current write).
REQ-020 Unprimed EN: sample written, fill increments, Xin_DELAY holds, DOUT_VALID=0.
REQ-021 Xin_DELAY holds its value in every cycle without DOUT_VALID.
REQ-022 BUSY = registered (fill < active_delay), updated every cycle.
REQ-023 LOAD: active_delay <= min(DELAY_LEN, MAX_DEPTH); fill <= 0; wr_ptr not changed; Xin_DELAY holds.
REQ-024 LOAD and EN same cycle: LOAD applied first; that sample is written and counted (fill <= 1); DOUT_VALID=0 unless new delay is 0, then pass-through per REQ-018.
REQ-025 DELAY_LEN > MAX_DEPTH clamps to MAX_DEPTH; no error flag.
REQ-026 Back-to-back EN every cycle supported at full throughput; no stall.

Reset
REQ-027 RST_N=0 at a rising edge: Xin_DELAY=0, DOUT_VALID=0, wr_ptr=0, fill=0, active_delay=min(DELAY_INIT, MAX_DEPTH); BUSY=1 the next cycle if DELAY_INIT>0, else 0.
REQ-028 Buffer contents not reset; stale words never reach Xin_DELAY because output gated by priming (REQ-020).
REQ-029 Reset mid-operation dominates EN and LOAD in the same cycle; in-flight samples discarded.

Verification
REQ-030 Reset, DELAY_INIT=1, EN continuous, Xin=1,2,3,... -> first DOUT_VALID on the cycle after Xin=2 accepted, Xin_DELAY=1; then 2,3,... each cycle.
REQ-031 LOAD DELAY_LEN=5, EN continuous, Xin=10..20 -> BUSY high 5 samples, first valid Xin_DELAY=10 after Xin=15 accepted; DOUT_VALID=0 for the first 5 strobes.
REQ-032 DELAY_LEN=MAX_DEPTH (64), 200 ramp samples -> Xin_DELAY = Xin-64 across at least two pointer wraps.
REQ-033 D=3, EN toggling 1/0 irregularly -> output equals the sample 3 strobes earlier; Xin_DELAY holds and DOUT_VALID=0 in EN=0 cycles.
REQ-034 LOAD with EN, DELAY_LEN=0 -> DOUT_VALID same pulse next cycle, Xin_DELAY=that Xin; DELAY_LEN=100 -> clamped to 64, BUSY for 64 samples.
REQ-035 RST_N low for one cycle mid-stream with LOAD=1 -> all outputs 0, active_delay=DELAY_INIT, LOAD ignored.

Source files
------------

// File: rtl/delay_line_prog.sv
// -----------------------------------------------------------------------------
// delay_line_prog
//
// Programmable sample delay line. Each accepted sample (EN=1) is written into a
// circular buffer. The sample accepted D strobes earlier is presented on
// Xin_DELAY one clock later, where D is the active delay. Time is counted in
// accepted samples, not in clock cycles, so idle cycles (EN=0) do not advance
// the line.
//
// After reset or LOAD, the line must be refilled ("primed") before its output
// is trusted. The fill counter counts accepted samples since that event. While
// fill < active_delay, samples are written but no output is produced. This
// keeps stale buffer contents away from Xin_DELAY.
//
// A delay of zero bypasses the buffer, so Xin is registered straight through.
// A delay of MAX_DEPTH reads the word that is being overwritten in the same
// cycle; the buffer read sees the old word.
//
// Parameters
//   DATA_W      sample width in bits
//   MAX_DEPTH   largest supported delay in samples (power of two, >= 2)
//   LEN_W       width of DELAY_LEN; must be able to hold MAX_DEPTH
//   DELAY_INIT  active delay after reset (clamped to MAX_DEPTH)
//
// Ports
//   CLK         clock; every state update happens on its rising edge
//   RST_N       synchronous active-low reset
//   EN          sample strobe; Xin is accepted in a cycle where EN=1
//   Xin         input sample
//   DELAY_LEN   requested delay; sampled only when LOAD=1
//   LOAD        single-cycle request to adopt DELAY_LEN and restart priming
//   Xin_DELAY   registered delayed sample; holds between valid pulses
//   DOUT_VALID  single-cycle pulse marking a fresh value on Xin_DELAY
//   BUSY        registered "fill < active_delay": high while priming
// -----------------------------------------------------------------------------
module delay_line_prog #(
    parameter int DATA_W     = 16,
    parameter int MAX_DEPTH  = 64,
    parameter int LEN_W      = 7,
    parameter int DELAY_INIT = 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              EN,
    input  logic [DATA_W-1:0] Xin,
    input  logic [LEN_W-1:0]  DELAY_LEN,
    input  logic              LOAD,
    output logic [DATA_W-1:0] Xin_DELAY,
    output logic              DOUT_VALID,
    output logic              BUSY
);

    // -------------------------------------------------------------------------
    // Derived constants
    // -------------------------------------------------------------------------
    localparam int AW = $clog2(MAX_DEPTH);

    // MAX_DEPTH and the reset delay, expressed at the width of the delay and
    // fill registers. DELAY_INIT is clamped here in the same way as a
    // DELAY_LEN that is too large.
    localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(MAX_DEPTH);
    localparam logic [LEN_W-1:0] INIT_L  =
        (DELAY_INIT > MAX_DEPTH) ? DEPTH_L : LEN_W'(DELAY_INIT);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [DATA_W-1:0] mem [MAX_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [LEN_W-1:0]  fill;          // accepted samples since reset/LOAD, saturating
    logic [LEN_W-1:0]  active_delay;

    // -------------------------------------------------------------------------
    // Next-state helpers
    // -------------------------------------------------------------------------
    logic [LEN_W-1:0]  len_clamped;   // DELAY_LEN limited to MAX_DEPTH
    logic [LEN_W-1:0]  delay_eff;     // delay that governs this cycle
    logic [LEN_W-1:0]  fill_eff;      // fill count before this cycle's write
    logic [LEN_W-1:0]  fill_next;
    logic [AW-1:0]     rd_addr;
    logic              pass_thru;
    logic              primed;
    logic [DATA_W-1:0] rd_data;

    // LOAD takes effect before a sample accepted in the same cycle. The
    // "effective" delay and fill values therefore already reflect the new
    // request when the priming decision for that sample is made.
    always_comb begin
        // NOTE: every signal is assigned before any condition, so no path
        // leaves a value undriven and no latch can be inferred.
        len_clamped = DELAY_LEN;
        delay_eff   = active_delay;
        fill_eff    = fill;
        fill_next   = fill;

        if (DELAY_LEN > DEPTH_L) begin
            len_clamped = DEPTH_L;
        end

        if (LOAD) begin
            delay_eff = len_clamped;
            fill_eff  = '0;
        end

        // The fill count saturates at MAX_DEPTH. A longer history is never
        // needed, because the largest possible delay is MAX_DEPTH.
        fill_next = fill_eff;
        if (EN && (fill_eff != DEPTH_L)) begin
            fill_next = fill_eff + LEN_W'(1);
        end

        pass_thru = (delay_eff == '0);
        primed    = (fill_eff >= delay_eff);

        // Modulo-MAX_DEPTH subtraction falls out of the natural wrap of the
        // AW-bit pointer. For delay == MAX_DEPTH, the low bits are zero, so
        // rd_addr == wr_ptr. That location holds the oldest sample, which is
        // about to be overwritten in this cycle.
        rd_addr = wr_ptr - delay_eff[AW-1:0];

        // With a delay of zero, rd_addr equals wr_ptr and would return the old
        // word. The zero-delay case therefore takes Xin directly.
        rd_data = pass_thru ? Xin : mem[rd_addr];
    end

    // -------------------------------------------------------------------------
    // Sample buffer
    // -------------------------------------------------------------------------
    // NOTE: the storage array has no reset. Clearing it would require a
    // separate write port or a multi-cycle sweep. The priming gate already
    // guarantees that a word is read only after it has been written since the
    // last reset or LOAD. Writes are suppressed during reset so that a sample
    // offered in that cycle is discarded.
    always_ff @(posedge CLK) begin
        if (RST_N && EN) begin
            mem[wr_ptr] <= Xin;
        end
    end

    // -------------------------------------------------------------------------
    // Control and output registers
    // -------------------------------------------------------------------------
    // NOTE: all sequential state uses non-blocking assignments. Every register
    // then samples the pre-edge values, which makes the read of mem above see
    // the old word at wr_ptr even while the same word is being written.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            wr_ptr       <= '0;
            fill         <= '0;
            active_delay <= INIT_L;
            Xin_DELAY    <= '0;
            DOUT_VALID   <= 1'b0;
            BUSY         <= (INIT_L != '0);
        end else begin
            active_delay <= delay_eff;
            fill         <= fill_next;
            BUSY         <= (fill_next < delay_eff);
            DOUT_VALID   <= 1'b0;

            if (EN) begin
                wr_ptr <= wr_ptr + AW'(1);

                // A delay of zero counts as primed immediately, because any
                // fill count is >= 0. Xin_DELAY keeps its previous value
                // whenever no valid sample is produced.
                if (primed) begin
                    Xin_DELAY  <= rd_data;
                    DOUT_VALID <= 1'b1;
                end
            end
        end
    end

endmodule
